// File: rtl/bayer2rgb_if.sv
// bayer2rgb_if: pixel stream bundle between the capture path and the demosaicer.
//
// Signals (i* flow into the demosaicer, o* flow out of it):
//   iData[7:0]   raw Bayer sample
//   iHSync       horizontal sync, passed through
//   iVSync       vertical sync, passed through
//   iLineValid   sample valid within a line
//   iFrameValid  frame active
//   oR/oG/oB     demosaiced colour, 8 bits each
//   oHSync, oVSync, oLineValid, oFrameValid   inputs delayed by two clocks
//
// Handshake: a pure streaming interface with no back-pressure. A raw sample
// transfers on every clock where iLineValid && iFrameValid are both high; the
// sink must take every sample, so there is no ready signal. The output side
// mirrors this: oLineValid && oFrameValid qualify oR/oG/oB.
//
// Modports: master = stream source/sink side (drives i*, observes o*),
//           slave  = the demosaicer (observes i*, drives o*).
interface bayer2rgb_if;
  logic [7:0] iData;
  logic       iHSync;
  logic       iVSync;
  logic       iLineValid;
  logic       iFrameValid;
  logic [7:0] oR;
  logic [7:0] oG;
  logic [7:0] oB;
  logic       oHSync;
  logic       oVSync;
  logic       oLineValid;
  logic       oFrameValid;

  modport master (
    output iData, iHSync, iVSync, iLineValid, iFrameValid,
    input  oR, oG, oB, oHSync, oVSync, oLineValid, oFrameValid
  );

  modport slave (
    input  iData, iHSync, iVSync, iLineValid, iFrameValid,
    output oR, oG, oB, oHSync, oVSync, oLineValid, oFrameValid
  );
endinterface

// File: rtl/bayer2rgb.sv
// bayer2rgb: 2x2-window Bayer demosaicer, one RGB pixel out per raw pixel in.
//
// The window is {aboveLeft, above, left, cur}: the current line supplies cur
// and left, a one-line buffer supplies the raw samples directly above. The
// window always holds one R, one B and two G sites; G is the truncated mean
// of the two G sites. Data and all sync/valid signals leave exactly two
// clocks after they enter.
//
// Parameters:
//   LINE_WIDTH  max pixels per line held in the line buffer
//   PATTERN     colour phase at (x=0,y=0): 0=GRBG, 1=RGGB, 2=BGGR, 3=GBRG
//
// Ports:
//   iClk    pixel clock
//   iRst    synchronous, active-high reset
//   bus     bayer2rgb_if.slave stream (raw in, RGB + delayed syncs out)
//   oState  debug view of the frame FSM: 0=WAIT_IDLE, 1=IDLE, 2=ACTIVE
module bayer2rgb #(
  parameter int LINE_WIDTH = 640,
  parameter int PATTERN    = 0
) (
  input  logic        iClk,
  input  logic        iRst,
  bayer2rgb_if.slave  bus,
  output logic [1:0]  oState
);

  localparam int AW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  // x must be able to hold LINE_WIDTH itself so it can saturate there.
  localparam int XW = $clog2(LINE_WIDTH + 1);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  state_t         state;
  logic [XW-1:0]  x;
  logic           yPar;      // line parity
  logic           yNonZero;  // cleared only for the first line of a frame
  logic           lvPrev;

  logic [7:0]     lineBuf [LINE_WIDTH];

  logic           accept;
  logic           inRange;
  logic           lvFall;
  logic [AW-1:0]  addr;

  // Stage 1
  logic [7:0]     s1Cur, s1Left, s1Above, s1AboveLeft;
  logic [1:0]     s1Phase;   // {y[0],x[0]} ^ PATTERN, i.e. the GRBG phase of cur
  logic           s1Pix;     // accepted and inside the buffer
  logic           s1First;   // first line or first column
  logic           s1HSync, s1VSync, s1LineValid, s1FrameValid;
  logic           s1Wait;    // stage-1 state was WAIT_IDLE

  // Stage 2 (outputs)
  logic [7:0]     rOut, gOut, bOut;
  logic           hsOut, vsOut, lvOut, fvOut;

  logic [7:0]     rSel, bSel;
  logic [8:0]     gSum;

  assign accept  = bus.iLineValid && bus.iFrameValid && (state == ACTIVE);
  assign inRange = (x < XW'(LINE_WIDTH));
  assign lvFall  = lvPrev && !bus.iLineValid;
  // Saturated x would point past the buffer; park the address at 0 instead.
  assign addr    = inRange ? x[AW-1:0] : '0;

  // Read-before-write: the read in stage 1 sees the previous line's sample.
  always_ff @(posedge iClk) begin
    if (accept && inRange) begin
      lineBuf[addr] <= bus.iData;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state        <= WAIT_IDLE;
      x            <= '0;
      yPar         <= 1'b0;
      yNonZero     <= 1'b0;
      lvPrev       <= 1'b0;
      s1Cur        <= '0;
      s1Left       <= '0;
      s1Above      <= '0;
      s1AboveLeft  <= '0;
      s1Phase      <= '0;
      s1Pix        <= 1'b0;
      s1First      <= 1'b0;
      s1HSync      <= 1'b0;
      s1VSync      <= 1'b0;
      s1LineValid  <= 1'b0;
      s1FrameValid <= 1'b0;
      s1Wait       <= 1'b0;
      rOut         <= '0;
      gOut         <= '0;
      bOut         <= '0;
      hsOut        <= 1'b0;
      vsOut        <= 1'b0;
      lvOut        <= 1'b0;
      fvOut        <= 1'b0;
    end else begin
      lvPrev <= bus.iLineValid;

      if (lvFall) begin
        x <= '0;
      end else if (accept && inRange) begin
        x <= x + XW'(1);
      end

      // A line that ends together with the frame does not advance y.
      if (state == IDLE) begin
        yPar     <= 1'b0;
        yNonZero <= 1'b0;
      end else if (lvFall && (state == ACTIVE) && bus.iFrameValid) begin
        yPar     <= ~yPar;
        yNonZero <= 1'b1;
      end

      // WAIT_IDLE skips whatever is left of a frame interrupted by reset.
      case (state)
        WAIT_IDLE: if (!bus.iFrameValid) state <= IDLE;
        IDLE:      if (bus.iFrameValid)  state <= ACTIVE;
        ACTIVE:    if (!bus.iFrameValid) state <= IDLE;
        default:   state <= WAIT_IDLE;
      endcase

      s1Cur        <= bus.iData;
      s1Left       <= s1Cur;
      s1Above      <= lineBuf[addr];
      s1AboveLeft  <= s1Above;
      s1Phase      <= {yPar, x[0]} ^ 2'(PATTERN);
      s1Pix        <= accept && inRange;
      s1First      <= !yNonZero || (x == '0);
      s1HSync      <= bus.iHSync;
      s1VSync      <= bus.iVSync;
      s1LineValid  <= bus.iLineValid;
      s1FrameValid <= bus.iFrameValid;
      s1Wait       <= (state == WAIT_IDLE);

      hsOut <= s1HSync;
      vsOut <= s1VSync;
      lvOut <= s1LineValid && !s1Wait;
      fvOut <= s1FrameValid && !s1Wait;
      if (s1Pix && !s1First && s1LineValid && !s1Wait) begin
        rOut <= rSel;
        gOut <= gSum[8:1];
        bOut <= bSel;
      end else begin
        rOut <= '0;
        gOut <= '0;
        bOut <= '0;
      end
    end
  end

  // Site roles by GRBG phase of cur (bottom-right of the window):
  //   00 G: left=R, above=B, aboveLeft=G   01 R: above/left=G, aboveLeft=B
  //   10 B: above/left=G, aboveLeft=R      11 G: above=R, left=B, aboveLeft=G
  always_comb begin
    rSel = '0;
    bSel = '0;
    gSum = '0;
    case (s1Phase)
      2'b00: begin
        rSel = s1Left;
        bSel = s1Above;
        gSum = 9'(s1Cur) + 9'(s1AboveLeft);
      end
      2'b01: begin
        rSel = s1Cur;
        bSel = s1AboveLeft;
        gSum = 9'(s1Left) + 9'(s1Above);
      end
      2'b10: begin
        rSel = s1AboveLeft;
        bSel = s1Cur;
        gSum = 9'(s1Left) + 9'(s1Above);
      end
      default: begin
        rSel = s1Above;
        bSel = s1Left;
        gSum = 9'(s1Cur) + 9'(s1AboveLeft);
      end
    endcase
  end

  assign bus.oR          = rOut;
  assign bus.oG          = gOut;
  assign bus.oB          = bOut;
  assign bus.oHSync      = hsOut;
  assign bus.oVSync      = vsOut;
  assign bus.oLineValid  = lvOut;
  assign bus.oFrameValid = fvOut;
  assign oState          = state;

endmodule
